uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx line among NREQ byte sources (start/data/stop framing).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 tx_busy,
  output logic                 tx
);

  localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] OS_LAST   = TW'(OS - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [TW-1:0]   tick;
  logic [BW-1:0]   bitc;
  logic [DBIT-1:0] shift;
  logic [DBIT-1:0] shift_nx;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   sel;
  logic            found;
  logic [DBIT-1:0] sel_data;
`ifdef UART_TX_PARITY_EN
  logic            parity;
`endif

  // Search upward from the requester after the last one served, wrapping around.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (!found && req_valid[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  assign sel_data = req_data[int'(sel)*DBIT +: DBIT];
  assign shift_nx = shift >> 1;

  // Ready is a same-cycle handshake: it can only rise while the line is free.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !reset)
      req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bitc       <= '0;
      shift      <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NREQ - 1);
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            shift      <= sel_data;
            grant_id   <= sel;
            last_grant <= sel;
            tick       <= '0;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
`ifdef UART_TX_PARITY_EN
            parity     <= ^sel_data;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (tick == OS_LAST) begin
              tick  <= '0;
              bitc  <= '0;
              tx    <= shift[0];
              state <= DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick == OS_LAST) begin
              tick  <= '0;
              shift <= shift_nx;
              if (bitc == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx    <= parity;
                state <= PARITY;
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                bitc <= bitc + 1'b1;
                tx   <= shift_nx[0];
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick == OS_LAST) begin
              tick  <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          // Returning to IDLE here lets the next frame be accepted on the very next clk.
          if (s_tick) begin
            if (tick == STOP_LAST) begin
              tick    <= '0;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
